// File: rtl/page_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : page_cmd_queue
// Description : Buffers page ADD/DEL commands and issues them one at a time to
//               the page map, holding each until the map reports completion.
//               Optional watchdog on the map handshake: PAGE_CMD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module page_cmd_queue #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk200,
    input  logic                   a8_rst,
    input  logic                   cmd_wr,
    input  logic [1:0]             cmd_op,
    input  logic [7:0]             cmd_from,
    input  logic [7:0]             cmd_size,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_count,
    input  logic                   map_valid,
    output logic [1:0]             op,
    output logic [7:0]             from,
    output logic [7:0]             size,
    output logic                   busy,
    output logic [7:0]             drop_cnt,
    output logic                   timeout_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [1:0] c_OP_NONE = 2'd0;
    localparam logic [1:0] c_OP_ADD  = 2'd1;
    localparam logic [1:0] c_OP_DEL  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [17:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] w_count_nxt;
    logic            r_full;

    logic [1:0]      r_op;
    logic [7:0]      r_from;
    logic [7:0]      r_size;
    logic [7:0]      r_drop;

    logic            w_op_ok;
    logic            w_push;
    logic            w_pop;
    logic            w_reject;
    logic [8:0]      w_sum;
    logic [7:0]      w_size_clip;
    logic [17:0]     w_head;

`ifdef PAGE_CMD_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);
    logic [c_TW-1:0] r_to_cnt;
    logic            r_to_err;
    logic            w_timeout;
`endif

    // ------------------------------------------------------------------
    // Write acceptance and clipping
    // ------------------------------------------------------------------
    assign w_op_ok  = (cmd_op == c_OP_ADD) | (cmd_op == c_OP_DEL);
    assign w_push   = cmd_wr & w_op_ok & (cmd_size != 8'd0) & ~r_full;
    assign w_reject = cmd_wr & w_op_ok & ((cmd_size == 8'd0) | r_full);
    assign w_sum    = {1'b0, cmd_from} + {1'b0, cmd_size};
    // Clipping only happens with from >= 2, so 0-from (mod 256) equals 256-from.
    assign w_size_clip = (w_sum > 9'd256) ? (8'd0 - cmd_from) : cmd_size;

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CW'(1);
            2'b01:   w_count_nxt = r_count - c_CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk200) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_from, w_size_clip};
        end
    end

    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CW'(DEPTH));
        end
    end

    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            r_drop <= 8'd0;
        end else if (w_reject && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
`ifdef PAGE_CMD_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && map_valid) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!map_valid) begin
                    w_state_nxt = S_WAIT_DONE;
                end
`ifdef PAGE_CMD_TIMEOUT_EN
                else if (r_to_cnt == c_TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (map_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // from/size stay loaded until the next pop so the map sees a stable run.
    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            r_op   <= c_OP_NONE;
            r_from <= 8'd0;
            r_size <= 8'd0;
        end else if (w_pop) begin
            r_op   <= w_head[17:16];
            r_from <= w_head[15:8];
            r_size <= w_head[7:0];
        end else if (r_state == S_ISSUE) begin
            r_op   <= c_OP_NONE;
        end
    end

`ifdef PAGE_CMD_TIMEOUT_EN
    always_ff @(posedge clk200) begin
        if (a8_rst || (r_state != S_WAIT_BUSY)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TW'(1);
        end
    end

    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            r_to_err <= 1'b0;
        end else if (w_timeout) begin
            r_to_err <= 1'b1;
        end
    end

    assign timeout_err = r_to_err;
`else
    assign timeout_err = 1'b0;
`endif

    assign cmd_full  = r_full;
    assign cmd_count = r_count;
    assign op        = r_op;
    assign from      = r_from;
    assign size      = r_size;
    assign drop_cnt  = r_drop;
    assign busy      = (r_state != S_IDLE) | (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_page_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_page_cmd_queue
// Description : Directed and randomized bench for page_cmd_queue against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_page_cmd_queue;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic       clk200 = 1'b0;
    logic       a8_rst = 1'b1;
    logic       cmd_wr = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_from = 8'd0;
    logic [7:0] cmd_size = 8'd0;
    logic       cmd_full;
    logic [$clog2(DEPTH):0] cmd_count;
    logic       map_valid = 1'b1;
    logic [1:0] op;
    logic [7:0] from;
    logic [7:0] size;
    logic       busy;
    logic [7:0] drop_cnt;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk200 = ~clk200;

    page_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk200(clk200), .a8_rst(a8_rst), .cmd_wr(cmd_wr), .cmd_op(cmd_op),
        .cmd_from(cmd_from), .cmd_size(cmd_size), .cmd_full(cmd_full),
        .cmd_count(cmd_count), .map_valid(map_valid), .op(op), .from(from),
        .size(size), .busy(busy), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    // Reference model: a queue of accepted commands plus the in-flight handshake.
    bit [17:0]  mq[$];
    bit         m_inf, m_low, m_terr;
    int         m_age, m_drop;
    logic [1:0] m_op;
    logic [7:0] m_from, m_size;
    bit         mp_pop, mp_push;
    bit [17:0]  mp_e, mp_h;
    int         mp_s;

    function automatic int clip_size(input int f, input int s);
        return (f + s > 256) ? 256 - f : s;
    endfunction

    always @(posedge clk200) begin
        if (a8_rst) begin
            mq.delete();
            m_inf = 0; m_low = 0; m_terr = 0; m_age = 0; m_drop = 0;
            m_op = 2'd0; m_from = 8'd0; m_size = 8'd0;
        end else begin
            mp_pop  = !m_inf && (mq.size() > 0) && map_valid;
            mp_push = 0;
            if (cmd_wr && (cmd_op == 2'd1 || cmd_op == 2'd2)) begin
                if (cmd_size == 8'd0 || mq.size() == DEPTH) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mp_push = 1;
                    mp_s = clip_size(int'(cmd_from), int'(cmd_size));
                    mp_e = {cmd_op, cmd_from, 8'(mp_s)};
                end
            end
            if (m_inf) begin
                if (m_age == 0) m_op = 2'd0;
                else if (!m_low) begin
                    if (!map_valid) m_low = 1;
`ifdef PAGE_CMD_TIMEOUT_EN
                    else if (m_age == TIMEOUT) begin m_inf = 0; m_terr = 1; end
`endif
                end else if (map_valid) m_inf = 0;
                m_age++;
            end
            if (mp_pop) begin
                mp_h = mq.pop_front();
                m_op = mp_h[17:16]; m_from = mp_h[15:8]; m_size = mp_h[7:0];
                m_inf = 1; m_low = 0; m_age = 0;
            end
            if (mp_push) mq.push_back(mp_e);
        end
    end

    task automatic tick;
        @(posedge clk200);
        @(negedge clk200);
    endtask

    task automatic do_reset;
        a8_rst = 1; cmd_wr = 0; map_valid = 1;
        tick; tick;
        a8_rst = 0;
    endtask

    task automatic write_cmd(input logic [1:0] o, input logic [7:0] f, input logic [7:0] s);
        cmd_wr = 1; cmd_op = o; cmd_from = f; cmd_size = s;
        tick;
        cmd_wr = 0;
    endtask

    task automatic test_reset;
        a8_rst = 1; map_valid = 1;
        cmd_wr = 1; cmd_op = 2'd1; cmd_from = 8'h33; cmd_size = 8'h3;
        tick;
        cmd_wr = 0;
        tick;
        n_vec++; if (op !== 2'd0) begin n_err++; $display("FAIL reset_op got %0d want 0", op); end
        n_vec++; if (from !== 8'd0 || size !== 8'd0) begin n_err++; $display("FAIL reset_from_size got %h/%h want 00/00", from, size); end
        n_vec++; if (cmd_full !== 1'b0 || cmd_count !== '0) begin n_err++; $display("FAIL reset_fifo got full=%b cnt=%0d want 0/0", cmd_full, cmd_count); end
        n_vec++; if (busy !== 1'b0 || drop_cnt !== 8'd0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_status got busy=%b drop=%0d to=%b want 0/0/0", busy, drop_cnt, timeout_err); end
        a8_rst = 0;
        tick;
    endtask

    task automatic test_single;
        map_valid = 1;
        write_cmd(2'd1, 8'h10, 8'd4);
        n_vec++; if (op !== 2'd0 || cmd_count !== 4'd1) begin n_err++; $display("FAIL single_pre got op=%0d cnt=%0d want 0/1", op, cmd_count); end
        tick;
        n_vec++; if (op !== 2'd1 || from !== 8'h10 || size !== 8'd4) begin n_err++; $display("FAIL single_issue got %0d/%h/%h want 1/10/04", op, from, size); end
        tick;
        n_vec++; if (op !== 2'd0 || busy !== 1'b1) begin n_err++; $display("FAIL single_oneshot got op=%0d busy=%b want 0/1", op, busy); end
        tick; tick; tick;
        n_vec++; if (busy !== 1'b1 || from !== 8'h10) begin n_err++; $display("FAIL single_hold got busy=%b from=%h want 1/10", busy, from); end
        map_valid = 0;
        tick;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_waitdone got busy=%b want 1", busy); end
        map_valid = 1;
        tick;
        n_vec++; if (busy !== 1'b0 || size !== 8'd4) begin n_err++; $display("FAIL single_done got busy=%b size=%h want 0/04", busy, size); end
    endtask

    task automatic test_clip;
        int k;
        int seen;
        map_valid = 1;
        write_cmd(2'd2, 8'hF0, 8'h20);
        k = 0;
        while (op === 2'd0 && k < 10) begin tick; k++; end
        n_vec++; if (op !== 2'd2 || from !== 8'hF0 || size !== 8'h10) begin n_err++; $display("FAIL clip_issue got %0d/%h/%h want 2/f0/10", op, from, size); end
        tick;
        map_valid = 0; tick;
        map_valid = 1; tick;
        write_cmd(2'd1, 8'd5, 8'd0);
        n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL clip_zero_drop got %0d want 1", drop_cnt); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick; if (op !== 2'd0) seen++; end
        n_vec++; if (seen !== 0 || cmd_count !== '0) begin n_err++; $display("FAIL clip_zero_noissue got ops=%0d cnt=%0d want 0/0", seen, cmd_count); end
    endtask

    task automatic test_full;
        int got, ph, cyc;
        logic [17:0] exp_e;
        do_reset;
        map_valid = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            write_cmd((i % 2) ? 2'd2 : 2'd1, 8'(i * 20), 8'(i + 1));
            if (i == DEPTH - 1) begin
                n_vec++; if (cmd_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b want 1", cmd_full); end
            end
        end
        n_vec++; if (drop_cnt !== 8'd1 || cmd_count !== 4'(DEPTH)) begin n_err++; $display("FAIL full_drop got drop=%0d cnt=%0d want 1/%0d", drop_cnt, cmd_count, DEPTH); end
        got = 0; ph = 0; cyc = 0;
        map_valid = 1;
        while (got < DEPTH && cyc < 200) begin
            tick; cyc++;
            if (ph == 0) begin
                if (op !== 2'd0) begin
                    exp_e = {((got % 2) ? 2'd2 : 2'd1), 8'(got * 20), 8'(got + 1)};
                    n_vec++; if ({op, from, size} !== exp_e) begin n_err++; $display("FAIL full_order[%0d] got %h want %h", got, {op, from, size}, exp_e); end
                    got++; ph = 1;
                end
            end else if (ph == 1) begin
                if (op !== 2'd0) begin n_err++; $display("FAIL full_double_issue got op=%0d want 0", op); end
                map_valid = 0; ph = 2;
            end else begin
                map_valid = 1; ph = 0;
            end
        end
        n_vec++; if (got !== DEPTH) begin n_err++; $display("FAIL full_drain got %0d ops want %0d", got, DEPTH); end
    endtask

    task automatic test_back_to_back;
        logic [17:0] cmds [4];
        int got, ph, cyc, f, s;
        do_reset;
        map_valid = 0;
        for (int i = 0; i < 4; i++) begin
            f = int'($urandom_range(0, 255)); s = int'($urandom_range(1, 255));
            cmds[i] = {((i % 2) ? 2'd1 : 2'd2), 8'(f), 8'(clip_size(f, s))};
            if (i < 3) write_cmd(cmds[i][17:16], 8'(f), 8'(s));
            else begin
                map_valid = 1;
                write_cmd(cmds[i][17:16], 8'(f), 8'(s));
            end
            if (i == 2) begin
                n_vec++; if (cmd_count !== 4'd3) begin n_err++; $display("FAIL b2b_fill got %0d want 3", cmd_count); end
            end
        end
        n_vec++; if (cmd_count !== 4'd3 || {op, from, size} !== cmds[0]) begin n_err++; $display("FAIL b2b_pushpop got cnt=%0d cmd=%h want 3/%h", cmd_count, {op, from, size}, cmds[0]); end
        got = 1; ph = 1; cyc = 0;
        while (got < 4 && cyc < 100) begin
            tick; cyc++;
            if (ph == 0) begin
                if (op !== 2'd0) begin
                    n_vec++; if ({op, from, size} !== cmds[got]) begin n_err++; $display("FAIL b2b_order[%0d] got %h want %h", got, {op, from, size}, cmds[got]); end
                    got++; ph = 1;
                end
            end else if (ph == 1) begin
                map_valid = 0; ph = 2;
            end else begin
                map_valid = 1; ph = 0;
            end
        end
        n_vec++; if (got !== 4) begin n_err++; $display("FAIL b2b_drain got %0d ops want 4", got); end
        tick; tick;
    endtask

    task automatic test_reset_mid;
        int seen;
        do_reset;
        map_valid = 0;
        write_cmd(2'd1, 8'd1, 8'd1);
        write_cmd(2'd2, 8'd2, 8'd2);
        write_cmd(2'd1, 8'd3, 8'd3);
        map_valid = 1;
        tick;
        map_valid = 0;
        tick; tick;
        n_vec++; if (cmd_count !== 4'd2 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got cnt=%0d busy=%b want 2/1", cmd_count, busy); end
        a8_rst = 1;
        tick;
        n_vec++; if (op !== 2'd0 || cmd_count !== '0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_clear got op=%0d cnt=%0d busy=%b want 0/0/0", op, cmd_count, busy); end
        a8_rst = 0; map_valid = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin tick; if (op !== 2'd0) seen++; end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_noissue got %0d ops want 0", seen); end
    endtask

    task automatic test_drop_sat;
        do_reset;
        map_valid = 0;
        write_cmd(2'd0, 8'd1, 8'd0);
        write_cmd(2'd3, 8'd1, 8'd5);
        n_vec++; if (drop_cnt !== 8'd0 || cmd_count !== '0) begin n_err++; $display("FAIL drop_badop got drop=%0d cnt=%0d want 0/0", drop_cnt, cmd_count); end
        cmd_wr = 1; cmd_op = 2'd1; cmd_size = 8'd0;
        for (int i = 0; i < 300; i++) tick;
        cmd_wr = 0;
        n_vec++; if (drop_cnt !== 8'd255) begin n_err++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
        map_valid = 1;
    endtask

`ifdef PAGE_CMD_TIMEOUT_EN
    task automatic test_timeout;
        int k;
        do_reset;
        map_valid = 1;
        write_cmd(2'd1, 8'h40, 8'd2);
        write_cmd(2'd2, 8'h50, 8'd3);
        k = 0;
        while (op === 2'd0 && k < 10) begin tick; k++; end
        k = 0;
        while (timeout_err !== 1'b1 && k < TIMEOUT + 20) begin tick; k++; end
        n_vec++; if (timeout_err !== 1'b1 || k < TIMEOUT - 2) begin n_err++; $display("FAIL timeout_flag got to=%b after %0d want 1 after ~%0d", timeout_err, k, TIMEOUT); end
        k = 0;
        while (op === 2'd0 && k < 10) begin tick; k++; end
        n_vec++; if (op !== 2'd2 || from !== 8'h50) begin n_err++; $display("FAIL timeout_next got %0d/%h want 2/50", op, from); end
    endtask
`endif

    task automatic test_random;
        do_reset;
        for (int i = 0; i < 1500; i++) begin
            cmd_wr    = ($urandom_range(0, 9) < 4);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_from  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom);
            cmd_size  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            map_valid = ($urandom_range(0, 9) < 6);
            a8_rst    = ($urandom_range(0, 299) == 0);
            tick;
            n_vec++; if (op !== m_op || from !== m_from || size !== m_size) begin n_err++; $display("FAIL rand_cmd[%0d] got %0d/%h/%h want %0d/%h/%h", i, op, from, size, m_op, m_from, m_size); end
            n_vec++; if (cmd_count !== 4'(mq.size()) || cmd_full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rand_fifo[%0d] got cnt=%0d full=%b want %0d", i, cmd_count, cmd_full, mq.size()); end
            n_vec++; if (busy !== (m_inf || mq.size() > 0)) begin n_err++; $display("FAIL rand_busy[%0d] got %b want %b", i, busy, (m_inf || mq.size() > 0)); end
            n_vec++; if (drop_cnt !== 8'(m_drop) || timeout_err !== m_terr) begin n_err++; $display("FAIL rand_status[%0d] got drop=%0d to=%b want %0d/%b", i, drop_cnt, timeout_err, m_drop, m_terr); end
        end
        a8_rst = 0; cmd_wr = 0;
    endtask

    initial begin
        @(negedge clk200);
        test_reset;
        test_single;
        test_clip;
        test_full;
        test_back_to_back;
        test_reset_mid;
        test_drop_sat;
`ifdef PAGE_CMD_TIMEOUT_EN
        test_timeout;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
